// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the single register-file write port among
// NUM_REQ writeback sources using one-entry buffers and round-robin issue.
//
// Ports:
//   clock            : system clock, all state on rising edge
//   ctrl_reset       : synchronous active-high reset
//   req_valid[i]     : requester i offers a write
//   req_ready[i]     : buffer i can accept a write this cycle
//   req_reg          : requester i index at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_data         : requester i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   ctrl_writeEnable : registered regfile write enable
//   ctrl_writeReg    : registered regfile write index
//   data_writeReg    : registered regfile write data
//   grant_id         : requester issued at the last edge
//   grant_valid      : a buffer was drained at the last edge (incl. r0 drops)
//   pending_mask     : bit r set while any buffer holds a write to r
//   zero_drops       : saturating count of discarded register-0 writes
module regfile_write_arbiter #(
   parameter int NUM_REQ    = 3,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                          clock,
   input  logic                          ctrl_reset,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_reg,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic                          ctrl_writeEnable,
   output logic [ADDR_WIDTH-1:0]         ctrl_writeReg,
   output logic [DATA_WIDTH-1:0]         data_writeReg,
   output logic [2:0]                    grant_id,
   output logic                          grant_valid,
   output logic [2**ADDR_WIDTH-1:0]      pending_mask,
   output logic [7:0]                    zero_drops
);

   logic [NUM_REQ-1:0]    buf_full;
   logic [ADDR_WIDTH-1:0] buf_reg  [NUM_REQ];
   logic [DATA_WIDTH-1:0] buf_data [NUM_REQ];

   logic [2:0]            rr_ptr;
   logic [2:0]            rr_next;

   logic                  found;
   logic [2:0]            win;
   logic [ADDR_WIDTH-1:0] win_reg;
   logic [DATA_WIDTH-1:0] win_data;
   logic [NUM_REQ-1:0]    grant;
   logic [NUM_REQ-1:0]    accept;

   // Round-robin search: first pass covers rr_ptr..NUM_REQ-1, second pass
   // wraps to the low indices. The winner's contents are muxed here too.
   always_comb begin
      found    = 1'b0;
      win      = '0;
      win_reg  = '0;
      win_data = '0;
      grant    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && buf_full[i] && i >= int'(rr_ptr)) begin
            found    = 1'b1;
            win      = 3'(i);
            win_reg  = buf_reg[i];
            win_data = buf_data[i];
            grant[i] = 1'b1;
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && buf_full[i]) begin
            found    = 1'b1;
            win      = 3'(i);
            win_reg  = buf_reg[i];
            win_data = buf_data[i];
            grant[i] = 1'b1;
         end
      end
   end

   always_comb begin
      if (int'(win) == NUM_REQ - 1) begin
         rr_next = '0;
      end else begin
         rr_next = win + 3'd1;
      end
   end

   // A buffer being drained this cycle may refill at the same edge.
   always_comb begin
      if (ctrl_reset) begin
         req_ready = '0;
      end else begin
         req_ready = ~buf_full | grant;
      end
   end

   assign accept = req_valid & req_ready;

   always_ff @(posedge clock) begin
      if (ctrl_reset) begin
         buf_full <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (accept[i]) begin
               buf_full[i] <= 1'b1;
            end else if (grant[i]) begin
               buf_full[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      for (int i = 0; i < NUM_REQ; i++) begin
         if (accept[i]) begin
            buf_reg[i]  <= req_reg[i*ADDR_WIDTH +: ADDR_WIDTH];
            buf_data[i] <= req_data[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (ctrl_reset) begin
         rr_ptr           <= '0;
         ctrl_writeEnable <= 1'b0;
         ctrl_writeReg    <= '0;
         data_writeReg    <= '0;
         grant_id         <= '0;
         grant_valid      <= 1'b0;
         zero_drops       <= '0;
      end else if (found) begin
         rr_ptr           <= rr_next;
         ctrl_writeEnable <= (win_reg != '0);
         ctrl_writeReg    <= win_reg;
         data_writeReg    <= win_data;
         grant_id         <= win;
         grant_valid      <= 1'b1;
         if (win_reg == '0 && zero_drops != 8'hFF) begin
            zero_drops <= zero_drops + 8'd1;
         end
      end else begin
         ctrl_writeEnable <= 1'b0;
         grant_valid      <= 1'b0;
      end
   end

   // A buffer being granted still counts as pending until its edge.
   always_comb begin
      pending_mask = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (buf_full[i]) begin
            pending_mask[buf_reg[i]] = 1'b1;
         end
      end
   end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port (ctrl_writeEnable / ctrl_writeReg / data_writeReg) among NUM_REQ writeback sources, e.g. ALU, mult/div unit and game I/O.
- Each source gets a one-entry holding buffer with a valid/ready handshake.
- A round-robin arbiter issues at most one registered write per cycle.
- Also exports a pending-write mask for hazard stalling and counts discarded writes to register 0.

Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8).
- DATA_WIDTH, 32, write data width.
- ADDR_WIDTH, 5, register index width (32 registers).

Ports:
- clock  input  1  system clock, all state on rising edge
- ctrl_reset  input  1  synchronous, active-high reset
- req_valid  input  NUM_REQ  bit i: requester i offers a write
- req_ready  output  NUM_REQ  bit i: buffer i can accept this cycle
- req_reg  input  NUM_REQ*ADDR_WIDTH  requester i index at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_data  input  NUM_REQ*DATA_WIDTH  requester i data at [i*DATA_WIDTH +: DATA_WIDTH]
- ctrl_writeEnable  output  1  registered regfile write enable
- ctrl_writeReg  output  ADDR_WIDTH  registered regfile write index
- data_writeReg  output  DATA_WIDTH  registered regfile write data
- grant_id  output  3  index of requester issued last cycle
- grant_valid  output  1  registered; a buffer was drained last edge, including register 0 drops
- pending_mask  output  2**ADDR_WIDTH  bit r set while any buffer holds a write to r
- zero_drops  output  8  saturating count of discarded register 0 writes

Behaviour:
- Reset: while ctrl_reset is high at a rising edge, all of the following are cleared:
  - buf_full[*], rr_ptr
  - ctrl_writeEnable, ctrl_writeReg, data_writeReg
  - grant_id, grant_valid, zero_drops
- During a reset cycle, req_ready is forced to 0 combinationally and no handshake completes.
- Reset asserted mid-operation discards all buffered writes; none are issued afterwards.
- Handshake: a transfer occurs at an edge where req_valid[i] && req_ready[i]. buf_reg[i] and buf_data[i] load, and buf_full[i] is set.
- Requester must hold reg and data stable while valid && !ready.
- req_ready[i] = !ctrl_reset && (!buf_full[i] || grant[i]). It depends only on buffer and arbiter state, never on req_valid.
- Arbitration is combinational each cycle over buf_full:
  - Winner is the first full buffer searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - At most one grant per cycle; no grant if all buffers are empty.
- Issue at the edge of a grant to winner w:
  - ctrl_writeReg and data_writeReg load buf[w]; grant_id = w; grant_valid = 1.
  - ctrl_writeEnable = 1 iff buf_reg[w] != 0.
  - rr_ptr = (w+1) mod NUM_REQ.
  - buf_full[w] clears, unless a new handshake on w completes the same edge, in which case it stays set with the new contents (no bubble).
- No grant: ctrl_writeEnable = 0 and grant_valid = 0. ctrl_writeReg and data_writeReg hold their previous values. rr_ptr holds.
- Register 0: buffer is consumed normally, but ctrl_writeEnable stays 0 and zero_drops increments, saturating at 255.
- Latency:
  - Handshake at edge N; earliest issue edge N+1.
  - ctrl_writeEnable is high during cycle N+1 and the regfile captures at edge N+2.
  - A sole active requester gets back-to-back writes, one per cycle.
- Fairness: with all NUM_REQ buffers continuously full, each requester is granted exactly once every NUM_REQ cycles.
- pending_mask is combinational: OR over i of buf_full[i] ? onehot(buf_reg[i]) : 0. A buffer being granted this cycle still counts as pending.
- Same register targeted by several buffers: issued in grant order, so the last-granted write wins in the regfile. No merging or reordering.

Test Plan:
- Reset then single write: req0 reg=5, data=0xDEADBEEF, one-cycle valid -> next cycle ctrl_writeEnable=1, ctrl_writeReg=5, data=0xDEADBEEF, grant_id=0. Following cycle enable=0.
- Contention: all three valid at the same edge (regs 1, 2, 3) -> grants 0, 1, 2 on consecutive cycles. rr_ptr returns to 0. req_ready of each waiting buffer stays 0 until its grant cycle.
- Continuous saturation: all requesters valid for 30 cycles -> exactly 10 grants each, strict rotation 0, 1, 2, 0, ...
- Register 0: req1 writes reg=0 three times -> ctrl_writeEnable never 1, grant_valid pulses 3 times, zero_drops=3. 300 drops -> zero_drops=255.
- Refill on grant: req2 held valid with new data every cycle -> writes issued every cycle with no bubble. pending_mask bit stays set throughout.
- Mid-operation reset: two buffers full, ctrl_reset high for 1 cycle -> pending_mask=0, no further writes, req_ready=0 during reset and all ones after.
